// File: rtl/dvp_frame_tx_if.sv
// Camera-side bundle of the DVP frame emulator: control handshake in, sensor bus out.
interface dvp_frame_tx_if;
  logic       start;
  logic       abort;
  logic [1:0] pattern_sel;
  logic       busy;
  logic       frame_done;
  logic       vsync;
  logic       href;
  logic       pclk;
  logic [7:0] pix_data;

  // Controller side: requests frames and watches the sensor bus.
  modport master (
    output start, abort, pattern_sel,
    input  busy, frame_done, vsync, href, pclk, pix_data
  );

  // Emulator side: drives the sensor bus.
  modport slave (
    input  start, abort, pattern_sel,
    output busy, frame_done, vsync, href, pclk, pix_data
  );
endinterface

// File: rtl/dvp_frame_tx.sv
// DVP (OV7670-style) camera emulator: emits one frame of vsync/href/pclk/pixel bytes
// with a selectable RGB565 test pattern each time start is accepted.
module dvp_frame_tx #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned HEIGHT    = 10,
  parameter int unsigned PCLK_DIV  = 1,
  parameter int unsigned VSYNC_LEN = 3,
  parameter int unsigned VBLANK    = 3,
  parameter int unsigned HBLANK    = 3
) (
  input logic          clk,
  input logic          rst_n,
  dvp_frame_tx_if.slave bus
);

  // One shared down-the-phase counter serves vsync, vblank and hblank intervals.
  localparam int unsigned CntMax0 = (VSYNC_LEN > VBLANK) ? VSYNC_LEN : VBLANK;
  localparam int unsigned CntMax  = (CntMax0 > HBLANK) ? CntMax0 : HBLANK;
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned PhW     = $clog2(2 * PCLK_DIV);
  localparam int unsigned XW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CntW-1:0] VsLast = CntW'(VSYNC_LEN - 1);
  localparam logic [CntW-1:0] VbLast = CntW'(VBLANK - 1);
  localparam logic [CntW-1:0] HbLast = CntW'(HBLANK - 1);
  localparam logic [PhW-1:0]  PhLast = PhW'(2 * PCLK_DIV - 1);
  localparam logic [PhW-1:0]  PhHigh = PhW'(PCLK_DIV);
  localparam logic [XW-1:0]   XLast  = XW'(WIDTH - 1);
  localparam logic [YW-1:0]   YLast  = YW'(HEIGHT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StVsLead,
    StVback,
    StLine,
    StHgap,
    StVsTrail,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PhW-1:0]  ph_q, ph_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            b_q, b_d;
  logic [1:0]      pat_q, pat_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       vsync_q, vsync_d;
  logic       href_q, href_d;
  logic       pclk_q, pclk_d;
  logic [7:0] pix_q, pix_d;

  // Frame sequencer: next state and pixel/line/phase counters.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    x_d     = x_q;
    y_d     = y_q;
    b_d     = b_q;
    pat_d   = pat_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          pat_d   = bus.pattern_sel;
          cnt_d   = '0;
          state_d = StVsLead;
        end
      end
      StVsLead: begin
        if (cnt_q == VsLast) begin
          cnt_d   = '0;
          state_d = StVback;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StVback: begin
        if (cnt_q == VbLast) begin
          x_d     = '0;
          y_d     = '0;
          b_d     = 1'b0;
          ph_d    = '0;
          state_d = StLine;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLine: begin
        if (ph_q == PhLast) begin
          ph_d = '0;
          if (!b_q) begin
            b_d = 1'b1;
          end else begin
            b_d = 1'b0;
            if (x_q == XLast) begin
              cnt_d   = '0;
              state_d = StHgap;
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end else begin
          ph_d = ph_q + PhW'(1);
        end
      end
      StHgap: begin
        if (cnt_q == HbLast) begin
          cnt_d = '0;
          if (y_q == YLast) begin
            state_d = StVsTrail;
          end else begin
            y_d     = y_q + YW'(1);
            x_d     = '0;
            state_d = StLine;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StVsTrail: begin
        if (cnt_q == VsLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort wins over everything, including a start seen in IDLE.
    if (bus.abort) begin
      state_d = StIdle;
    end
  end

  // Output values for the coming cycle, decoded from the next state so outputs are registered.
  always_comb begin
    busy_d  = (state_d != StIdle) && (state_d != StDone);
    done_d  = (state_d == StDone);
    vsync_d = (state_d == StVsLead) || (state_d == StVsTrail);
    href_d  = (state_d == StLine);
    pclk_d  = href_d && (ph_d >= PhHigh);
    pix_d   = 8'h00;
    if (href_d) begin
      case (pat_d)
        2'd0:    pix_d = b_d ? 8'hE0 : 8'h07;
        2'd1:    pix_d = b_d ? 8'hA0 : 8'h3C;
        2'd2:    pix_d = 8'(x_d);
        default: pix_d = (x_d[0] ^ y_d[0]) ? 8'hFF : 8'h00;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ph_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      b_q     <= 1'b0;
      pat_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      x_q     <= x_d;
      y_q     <= y_d;
      b_q     <= b_d;
      pat_q   <= pat_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      pclk_q  <= 1'b0;
      pix_q   <= 8'h00;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      pclk_q  <= pclk_d;
      pix_q   <= pix_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.vsync      = vsync_q;
  assign bus.href       = href_q;
  assign bus.pclk       = pclk_q;
  assign bus.pix_data   = pix_q;

endmodule
